// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the UART receive path: deframer
//                state encoding, parity mode constants, oversampling ratio
//                and the baud tick divisor helper.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Rounded clocks-per-oversample-tick: round(clk_hz / (baud * OVERSAMPLE)).
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : First-word-fall-through synchronous FIFO. Head entry is
//                always visible on o_pop_data (zero when empty). A push while
//                full is accepted only if a pop happens in the same cycle.
//                i_flush empties the FIFO and overrides any same-cycle push.
//  Ports       : clk, rst_n          clock, async active-low reset
//                i_push, i_push_data write strobe and data
//                i_pop               consume head (ignored when empty)
//                i_flush             synchronous empty
//                o_pop_data          head entry
//                o_valid             FIFO non-empty
//                o_count             occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign o_valid   = (r_count != '0);
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_do_pop  = i_pop && o_valid && !i_flush;
    // When full, a same-cycle pop frees the slot being written.
    assign w_do_push = i_push && (!w_full || w_do_pop) && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_pop_data = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_buffered
//  Description : Oversampling UART receiver with configurable character
//                width, parity and stop bits. Deframed characters are tagged
//                with parity/framing error flags and queued in a FWFT FIFO
//                drained over a valid/ready handshake.
//  Ports       : clk, rst_n     clock, async active-low reset
//                rx             asynchronous serial line, idle high
//                clear          clears overrun/frame_count, flushes FIFO
//                rx_data/perr/ferr/valid, rx_ready   head entry handshake
//                overrun        sticky: frame dropped on full FIFO
//                fifo_count     FIFO occupancy
//                frame_count    frames completed since reset/clear
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 19200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    input  logic                          clear,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   frame_count
);

    localparam int unsigned c_DIV       = uart_div(CLK_HZ, BAUD);
    localparam int unsigned c_TW        = $clog2(c_DIV + 1);
    localparam int unsigned c_CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
    localparam logic [3:0] c_LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_LAST_STOP  = 4'(STOP_BITS - 1);

    // Synchroniser and edge detect
    logic r_rx_meta, r_rx_sync, r_rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Free-running oversample tick
    logic [c_TW-1:0] r_tick_cnt;
    logic            w_tick;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_tick_cnt <= '0;
        else if (w_tick) r_tick_cnt <= '0;
        else             r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // Deframer
    rx_state_t              r_state, w_state_nxt;
    logic [3:0]             r_phase;
    logic [3:0]             r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr, r_ferr;

    logic w_mid, w_ferr_final, w_par_exp;
    logic w_phase_clr, w_frame_start, w_cnt_clr;
    logic w_shift_en, w_par_en, w_stop_en, w_commit;

    // Phase wraps 15 -> 0 every 16 ticks, so phase 15 is one bit after the
    // mid-start-bit point where the phase was cleared.
    assign w_mid        = w_tick && (r_phase == 4'd15);
    assign w_ferr_final = r_ferr || !r_rx_sync;
    assign w_par_exp    = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_clr   = 1'b0;
        w_frame_start = 1'b0;
        w_cnt_clr     = 1'b0;
        w_shift_en    = 1'b0;
        w_par_en      = 1'b0;
        w_stop_en     = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_nxt = ST_START;
                    w_phase_clr = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick && (r_phase == 4'd7)) begin
                    if (r_rx_sync) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt   = ST_DATA;
                        w_phase_clr   = 1'b1;
                        w_frame_start = 1'b1;
                        w_cnt_clr     = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_mid) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_DATA) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (w_mid) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_mid) begin
                    w_stop_en = 1'b1;
                    if (r_bit_cnt == c_LAST_STOP) begin
                        w_commit    = 1'b1;
                        w_state_nxt = w_ferr_final ? ST_BREAK : ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (r_rx_sync) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            if (w_phase_clr)  r_phase <= '0;
            else if (w_tick)  r_phase <= r_phase + 1'b1;

            if (w_cnt_clr)                      r_bit_cnt <= '0;
            else if (w_shift_en || w_stop_en)   r_bit_cnt <= r_bit_cnt + 1'b1;

            // LSB arrives first, so shift in from the top.
            if (w_shift_en) r_shift <= {r_rx_sync, r_shift[DATA_BITS-1:1]};

            if (w_frame_start)  r_perr <= 1'b0;
            else if (w_par_en)  r_perr <= (r_rx_sync != w_par_exp);

            if (w_frame_start)                  r_ferr <= 1'b0;
            else if (w_stop_en && !r_rx_sync)   r_ferr <= 1'b1;
        end
    end

    // Buffering and status
    logic [DATA_BITS+1:0] w_head;
    logic                 w_pop, w_full;

    assign w_pop  = rx_valid && rx_ready;
    assign w_full = (fifo_count == c_CW'(FIFO_DEPTH));

    sync_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_commit),
        .i_push_data ({w_ferr_final, r_perr, r_shift}),
        .i_pop       (w_pop),
        .i_flush     (clear),
        .o_pop_data  (w_head),
        .o_valid     (rx_valid),
        .o_count     (fifo_count)
    );

    assign {rx_ferr, rx_perr, rx_data} = w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            frame_count <= '0;
        end else if (clear) begin
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (w_commit)                      frame_count <= frame_count + 16'd1;
            if (w_commit && w_full && !w_pop)  overrun     <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffered.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_buffered
//  Description : Self-checking bench for uart_rx_buffered. Frames are built
//                bit by bit on rx; a queue-based model predicts the FIFO
//                contents, error tags, frame count and overrun flag.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    localparam int unsigned CLK_HZ = 640_000;
    localparam int unsigned BAUD   = 10_000;
    localparam int unsigned DW     = 8;
    localparam int unsigned PAR    = 1;          // even parity
    localparam int unsigned SB     = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int          BIT    = CLK_HZ / BAUD;   // 64 clocks per bit

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rx = 1'b1;
    logic           clear = 1'b0;
    logic           rx_ready = 1'b0;
    logic [DW-1:0]  rx_data;
    logic           rx_perr, rx_ferr, rx_valid, overrun;
    logic [2:0]     fifo_count;
    logic [15:0]    frame_count;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DW),
        .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .clear(clear),
        .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .overrun(overrun),
        .fifo_count(fifo_count), .frame_count(frame_count)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [9:0]  q[$];          // {ferr, perr, data}
    logic [15:0] exp_fc = '0;
    logic        exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clk);
    endtask

    // One frame: start, LSB-first data, parity (optionally wrong), two stop
    // bits, optional extra low hold, then one idle bit.
    task automatic send_frame(input logic [7:0] d, input bit par_err,
                              input bit s1, input bit s2, input int hold_low);
        logic pbit;
        pbit = (^d) ^ par_err;
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(s1);
        drive_bit(s2);
        for (int i = 0; i < hold_low; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        exp_fc = exp_fc + 16'd1;
        if (q.size() < DEPTH) q.push_back({~(s1 & s2), par_err, d});
        else                  exp_ovr = 1'b1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 16 * BIT && rx_valid !== 1'b1; i++) @(negedge clk);
        chk("valid_wait", {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic pop_one();
        logic [9:0] e;
        e = q.pop_front();
        wait_valid();
        chk("head_data", {24'd0, rx_data}, {24'd0, e[7:0]});
        chk("head_perr", {31'd0, rx_perr}, {31'd0, e[8]});
        chk("head_ferr", {31'd0, rx_ferr}, {31'd0, e[9]});
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        while (q.size() > 0) pop_one();
        chk("drained_valid", {31'd0, rx_valid}, 32'd0);
        chk("drained_count", {29'd0, fifo_count}, 32'd0);
        chk("frame_count", {16'd0, frame_count}, {16'd0, exp_fc});
        chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_data"},  {24'd0, rx_data}, 32'd0);
        chk({tag, "_perr"},  {31'd0, rx_perr}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, rx_ferr}, 32'd0);
        chk({tag, "_ovr"},   {31'd0, overrun}, 32'd0);
        chk({tag, "_count"}, {29'd0, fifo_count}, 32'd0);
        chk({tag, "_fc"},    {16'd0, frame_count}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        int         n;

        // Reset values
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);

        // Two clean characters
        send_frame(8'h55, 0, 1, 1, 0);
        send_frame(8'hA3, 0, 1, 1, 0);
        drain();

        // Parity: 0x07 needs parity bit 1 for even parity
        send_frame(8'h07, 1, 1, 1, 0);
        send_frame(8'h07, 0, 1, 1, 0);
        drain();

        // Stop low then line held low: one errored frame, then one good frame
        send_frame(8'h3C, 0, 0, 0, 3);
        send_frame(8'h3C, 0, 1, 1, 0);
        chk("break_fc", {16'd0, frame_count}, {16'd0, exp_fc});
        drain();

        // Only the second stop bit low
        send_frame(8'($urandom), 0, 1, 0, 0);
        drain();

        // Randomised bursts with occasional parity/framing errors
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++)
                send_frame(8'($urandom), ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0), 0);
            drain();
        end

        // Overrun: six frames into a four-entry FIFO
        for (int k = 0; k < 6; k++) send_frame(8'($urandom), 0, 1, 1, 0);
        chk("full_count", {29'd0, fifo_count}, DEPTH);
        chk("full_ovr", {31'd0, overrun}, {31'd0, exp_ovr});
        chk("full_fc", {16'd0, frame_count}, {16'd0, exp_fc});
        pop_one();
        pop_one();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        q.delete();
        exp_fc  = '0;
        exp_ovr = 1'b0;
        chk("clear_ovr", {31'd0, overrun}, 32'd0);
        chk("clear_count", {29'd0, fifo_count}, 32'd0);
        chk("clear_valid", {31'd0, rx_valid}, 32'd0);
        chk("clear_fc", {16'd0, frame_count}, 32'd0);

        // Short low glitch while idle
        send_frame(8'h96, 0, 1, 1, 0);
        @(negedge clk) rx = 1'b0;
        repeat (BIT / 2 - 8) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        chk("glitch_fc", {16'd0, frame_count}, {16'd0, exp_fc});
        drain();

        // Reset in the middle of the data bits, with an entry already queued
        send_frame(8'h5A, 0, 1, 1, 0);
        d = 8'($urandom);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        q.delete();
        exp_fc  = '0;
        exp_ovr = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        chk("midrst_idle_fc", {16'd0, frame_count}, 32'd0);
        send_frame(8'hC3, 0, 1, 1, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
